seg_scan_driver: RTL and testbench

Downstream consumer of the two-digit BCD counter. Takes packed 4-bit digit values and per-digit decimal points, and time-multiplexes them onto a common-pin seven-segment display. Provides a digit-select scan, hex segment decoding, leading-zero blanking and an inter-digit dead time against ghosting. Input digits are snapshotted once per frame so the display never tears mid-scan.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//
// Contents:
//   SEG_0 .. SEG_F  active-high 7-bit segment patterns, bit 0 = a .. bit 6 = g
//   SEG_BLANK       all segments off
//   state_e         scan FSM state encoding (SHOW, GAP)
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // SHOW: current digit lit; GAP: dead time with every digit dark.
    typedef enum logic [0:0] {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   value  in  4  digit value 0..F
//   blank  in  1  1 = force all segments off (leading-zero blanking)
//   seg    out 7  active-high segments, [0]=a .. [6]=g
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = SEG_A;
                4'hB:    seg = SEG_B;
                4'hC:    seg = SEG_C;
                4'hD:    seg = SEG_D;
                4'hE:    seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-pin seven-segment display.
//
// Each digit is lit for SCAN_DIV cycles, optionally followed by GAP_CYC cycles with all
// digits dark to avoid ghosting. Digit values and decimal points are captured into a
// snapshot once per frame (when the scan wraps back to digit 0) so a frame never shows a
// mix of old and new data. All pins are registered and lag the scan state by one cycle.
//
// Ports:
//   clk         in   1          system clock
//   rst_n       in   1          asynchronous active-low reset
//   en          in   1          display enable; 0 holds the scan at digit 0, pins dark
//   data_in     in   4*NUM_DIG  digit values, [3:0] = digit 0 (least significant)
//   dp_in       in   NUM_DIG    decimal point per digit, bit i = digit i
//   lz_blank    in   1          1 = blank leading zeros (sampled live)
//   seg_sel     out  NUM_DIG    one-hot digit select, active-low when SEL_ACT_LOW
//   seg_led     out  8          [0]=a .. [6]=g, [7]=dp, active-low when SEG_ACT_LOW
//   frame_tick  out  1          one-cycle pulse when the snapshot loads at frame wrap
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIG     = 2,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned GAP_CYC     = 0,
    parameter bit          SEL_ACT_LOW = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic                   lz_blank,
    output logic [NUM_DIG-1:0]     seg_sel,
    output logic [7:0]             seg_led,
    output logic                   frame_tick
);

    localparam int unsigned IdxW   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int unsigned CntMax = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [IdxW-1:0]    IdxLast  = IdxW'(NUM_DIG - 1);
    localparam logic [CntW-1:0]    ScanLast = CntW'(SCAN_DIV - 1);
    // Unreachable when GAP_CYC == 0; the truncated value is never compared in GAP.
    localparam logic [CntW-1:0]    GapLast  = CntW'(GAP_CYC - 1);

    localparam logic [NUM_DIG-1:0] SelOff = SEL_ACT_LOW ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};
    localparam logic [7:0]         LedOff = SEG_ACT_LOW ? 8'hFF : 8'h00;

    state_e                 state_q;
    logic [IdxW-1:0]        idx_q;
    logic [CntW-1:0]        div_cnt_q;
    logic [4*NUM_DIG-1:0]   snap_q;
    logic [NUM_DIG-1:0]     snap_dp_q;

    logic                   state_end;
    logic                   enter_show;
    logic                   wrap;
    logic [IdxW-1:0]        idx_next;
    logic [NUM_DIG-1:0]     lz_vec;
    logic                   zero_above;
    logic [3:0]             cur_digit;
    logic                   cur_blank;
    logic [6:0]             cur_seg;
    logic [NUM_DIG-1:0]     sel_on;
    logic [7:0]             led_on;

    // Scan sequencing: where the current state ends and what follows it.
    always_comb begin
        state_end  = (state_q == SHOW) ? (div_cnt_q == ScanLast) : (div_cnt_q == GapLast);
        enter_show = state_end && ((state_q == GAP) || (GAP_CYC == 0));
        wrap       = enter_show && (idx_q == IdxLast);
        idx_next   = wrap ? '0 : idx_q + IdxW'(1);
    end

    // lz_vec[i] is set when digit i and every digit above it are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int i = int'(NUM_DIG) - 1; i >= 0; i--) begin
            zero_above = zero_above & (snap_q[4*i +: 4] == 4'd0);
            lz_vec[i]  = zero_above;
        end
    end

    always_comb begin
        cur_digit = snap_q[{idx_q, 2'b00} +: 4];
        cur_blank = lz_blank && (idx_q != '0) && lz_vec[idx_q];
    end

    seg7_decode u_decode (
        .value (cur_digit),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    // Pin levels for the digit currently selected by the scan.
    always_comb begin
        sel_on = NUM_DIG'(1) << idx_q;
        led_on = {snap_dp_q[idx_q], cur_seg};
        if (SEL_ACT_LOW) begin
            sel_on = ~sel_on;
        end
        if (SEG_ACT_LOW) begin
            led_on = ~led_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHOW;
            idx_q      <= '0;
            div_cnt_q  <= '0;
            snap_q     <= '0;
            snap_dp_q  <= '0;
            frame_tick <= 1'b0;
            seg_sel    <= SelOff;
            seg_led    <= LedOff;
        end else if (!en) begin
            // Park at the start of a frame and keep the snapshot tracking the inputs, so
            // the first digit lit after enable shows current data without a tick.
            state_q    <= SHOW;
            idx_q      <= '0;
            div_cnt_q  <= '0;
            snap_q     <= data_in;
            snap_dp_q  <= dp_in;
            frame_tick <= 1'b0;
            seg_sel    <= SelOff;
            seg_led    <= LedOff;
        end else begin
            if (state_q == SHOW) begin
                seg_sel <= sel_on;
                seg_led <= led_on;
            end else begin
                seg_sel <= SelOff;
                seg_led <= LedOff;
            end

            frame_tick <= wrap;

            if (state_end) begin
                div_cnt_q <= '0;
                if (enter_show) begin
                    state_q <= SHOW;
                    idx_q   <= idx_next;
                    if (wrap) begin
                        snap_q    <= data_in;
                        snap_dp_q <= dp_in;
                    end
                end else begin
                    state_q <= GAP;
                end
            end else begin
                div_cnt_q <= div_cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver. Two instances share the inputs:
//   dut_a: NUM_DIG=2, SCAN_DIV=4, GAP_CYC=1, active-low select and segments
//   dut_b: NUM_DIG=2, SCAN_DIV=4, GAP_CYC=0, active-high select and segments
// The reference model tracks a frame position counter and derives lit digit / gap from
// plain division, rather than an explicit state machine.
module tb_seg_scan_driver;

    localparam int ND = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         lz_blank = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic [1:0]   dp_in = 2'b00;

    logic [1:0]   sel_a, sel_b;
    logic [7:0]   led_a, led_b;
    logic         ft_a, ft_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIG     (2),
        .SCAN_DIV    (4),
        .GAP_CYC     (1),
        .SEL_ACT_LOW (1'b1),
        .SEG_ACT_LOW (1'b1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg_sel    (sel_a),
        .seg_led    (led_a),
        .frame_tick (ft_a)
    );

    seg_scan_driver #(
        .NUM_DIG     (2),
        .SCAN_DIV    (4),
        .GAP_CYC     (0),
        .SEL_ACT_LOW (1'b0),
        .SEG_ACT_LOW (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .seg_sel    (sel_b),
        .seg_led    (led_b),
        .frame_tick (ft_b)
    );

    localparam logic [6:0] SEGS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int scan_c [2] = '{4, 4};
    int gap_c  [2] = '{1, 0};
    bit sel_lo [2] = '{1'b1, 1'b0};
    bit seg_lo [2] = '{1'b1, 1'b0};

    // Model state: position within the frame, snapshot, and expected pins.
    int         mpos  [2];
    logic [7:0] msnap [2];
    logic [1:0] mdp   [2];
    logic [1:0] esel  [2];
    logic [7:0] eled  [2];
    logic       eft   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_off(input int c);
        esel[c] = sel_lo[c] ? 2'b11 : 2'b00;
        eled[c] = seg_lo[c] ? 8'hFF : 8'h00;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mpos[c]  = 0;
            msnap[c] = 8'h00;
            mdp[c]   = 2'b00;
            eft[c]   = 1'b0;
            model_off(c);
        end
    endtask

    // Pins for the frame position currently held by the model.
    task automatic model_pins(input int c);
        int per, slot, ph;
        logic [1:0] s;
        logic [7:0] l;
        bit blank;
        per  = scan_c[c] + gap_c[c];
        slot = mpos[c] / per;
        ph   = mpos[c] % per;
        if (ph >= scan_c[c]) begin
            model_off(c);
        end else begin
            s     = 2'b01 << slot;
            blank = lz_blank && (slot != 0) && ((msnap[c] >> (slot * 4)) == 8'h00);
            l     = {mdp[c][slot], blank ? 7'h00 : SEGS[msnap[c][slot*4 +: 4]]};
            esel[c] = sel_lo[c] ? ~s : s;
            eled[c] = seg_lo[c] ? ~l : l;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                mpos[c]  = 0;
                msnap[c] = 8'h00;
                mdp[c]   = 2'b00;
                eft[c]   = 1'b0;
                model_off(c);
            end else if (!en) begin
                model_off(c);
                mpos[c]  = 0;
                msnap[c] = data_in;
                mdp[c]   = dp_in;
                eft[c]   = 1'b0;
            end else begin
                model_pins(c);
                mpos[c] = (mpos[c] + 1) % (ND * (scan_c[c] + gap_c[c]));
                if (mpos[c] == 0) begin
                    msnap[c] = data_in;
                    mdp[c]   = dp_in;
                    eft[c]   = 1'b1;
                end else begin
                    eft[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("sel_a", 32'(sel_a), 32'(esel[0]));
        check("led_a", 32'(led_a), 32'(eled[0]));
        check("ft_a",  32'(ft_a),  32'(eft[0]));
        check("sel_b", 32'(sel_b), 32'(esel[1]));
        check("led_b", 32'(led_b), 32'(eled[1]));
        check("ft_b",  32'(ft_b),  32'(eft[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_ft(input int which);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = (which == 0) ? ft_a : ft_b;
        end
        if (!seen) begin
            check("ft_timeout", 32'd0, 32'd1);
        end
    endtask

    // One dut_a frame starting just after its frame_tick; optional mid-frame data change.
    task automatic frame_a(input string tag, input logic [7:0] led0, input logic [7:0] led1,
                           input int chg_at, input logic [7:0] chg_data);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k <= 4) begin
                check({tag, "_sel0"}, 32'(sel_a), 32'h2);
                check({tag, "_led0"}, 32'(led_a), 32'(led0));
            end else if (k == 5 || k == 10) begin
                check({tag, "_selgap"}, 32'(sel_a), 32'h3);
                check({tag, "_ledgap"}, 32'(led_a), 32'hFF);
            end else begin
                check({tag, "_sel1"}, 32'(sel_a), 32'h1);
                check({tag, "_led1"}, 32'(led_a), 32'(led1));
            end
            check({tag, "_tick"}, 32'(ft_a), (k == 10) ? 32'd1 : 32'd0);
            if (k == chg_at) data_in = chg_data;
        end
    endtask

    task automatic do_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_sel_a", 32'(sel_a), 32'h3);
        check("rst_led_a", 32'(led_a), 32'hFF);
        compare_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        data_in = 8'h15;

        // Basic scan of "15" with gap, tick every 10 cycles.
        wait_ft(0);
        frame_a("s1", 8'h92, 8'hF9, 0, 8'h00);

        // Leading-zero blanking of "07", then unblanked.
        data_in  = 8'h07;
        lz_blank = 1'b1;
        wait_ft(0);
        frame_a("s2blank", 8'hF8, 8'hFF, 0, 8'h00);
        lz_blank = 1'b0;
        frame_a("s2noblank", 8'hF8, 8'hC0, 0, 8'h00);

        // Mid-frame data change is held off until the next wrap.
        data_in = 8'h15;
        wait_ft(0);
        frame_a("s3same", 8'h92, 8'hF9, 2, 8'h09);
        frame_a("s3next", 8'h90, 8'hC0, 0, 8'h00);

        // Blanked digit keeps its decimal point.
        data_in  = 8'h00;
        dp_in    = 2'b10;
        lz_blank = 1'b1;
        wait_ft(0);
        frame_a("s4", 8'hC0, 8'h7F, 0, 8'h00);

        // Enable drop mid-SHOW, re-enable with fresh data, reset mid-GAP.
        dp_in    = 2'b00;
        lz_blank = 1'b0;
        data_in  = 8'h42;
        wait_ft(0);
        step();
        step();
        en = 1'b0;
        step();
        check("s5_off_sel", 32'(sel_a), 32'h3);
        check("s5_off_led", 32'(led_a), 32'hFF);
        check("s5_off_ft",  32'(ft_a),  32'h0);
        data_in = 8'h37;
        step();
        step();
        en = 1'b1;
        step();
        check("s5_on_sel", 32'(sel_a), 32'h2);
        check("s5_on_led", 32'(led_a), 32'hF8);
        step();
        step();
        step();
        do_reset_mid();

        // No-gap, active-high instance showing "AF".
        data_in = 8'hAF;
        wait_ft(1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("s6_sel", 32'(sel_b), (k <= 4) ? 32'h1 : 32'h2);
            check("s6_led", 32'(led_b), (k <= 4) ? 32'h71 : 32'h77);
            check("s6_tick", 32'(ft_b), (k == 8) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0)   data_in  = 8'($urandom);
            if ($urandom_range(0, 15) == 0)  dp_in    = 2'($urandom);
            if ($urandom_range(0, 31) == 0)  lz_blank = ~lz_blank;
            if ($urandom_range(0, 5) == 0)   data_in[7:4] = 4'h0;
            if (en) begin
                if ($urandom_range(0, 59) == 0) en = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0)  en = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset_mid();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
